axi_pop_fsm_wr: RTL and testbench
=================================

# axi_pop_fsm_wr

Write-request pop stage of the AXI slave request path: drains one complete write request (AW entry plus its AWLEN+1 W beats) from the AW and W FIFOs filled by the write push FSM, and presents it to the TLP generator as a memory-write header followed by a data-beat stream. It also records the request tag/AWID pair in the request recorder so the completion path can return B. It sits between the AW/W sync FIFOs and the TX TLP generator.

## Interface
Parameters:
- ID_WIDTH, 4, AWID/WID width
- ADDR_WIDTH, 64, AWADDR width
- LEN_WIDTH, 8, AWLEN width
- DATA_WIDTH, 256, WDATA width; STRB_WIDTH = DATA_WIDTH/8
- AWUSER_WIDTH, 3, request type field
- TAG_WIDTH, 8, PCIe tag width

Ports:
- axi_clk  in  1  clock; single clock domain
- ARESTn  in  1  asynchronous active-low reset
- aw_fifo_if  Sync_FIFO_Interface.SINK_FIFO  —  FWFT read side: FIFO_rd_data = head {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWUSER, WSTRB}, FIFO_empty, FIFO_rd_en pops
- w_fifo_if  Sync_FIFO_Interface.SINK_FIFO  —  FWFT read side, FIFO_rd_data = WDATA
- rec_wr_en  out  1  recorder write strobe
- rec_wr_addr  out  TAG_WIDTH  recorder address = tag
- rec_wr_data  out  ID_WIDTH+1  {AWID, 1'b1} (bit0 = busy)
- hdr_valid  out  1  header valid
- hdr_ready  in  1  generator accepts header
- hdr_tag  out  TAG_WIDTH  = {1'b0, generate_tag(AWID)}
- hdr_addr  out  ADDR_WIDTH  AWADDR
- hdr_len_dw  out  10  payload length in DW (1024 encodes 0)
- hdr_first_be, hdr_last_be  out  4 each  byte enables
- hdr_type  out  AWUSER_WIDTH  AWUSER
- data_valid  out  1, data_ready  in  1, data  out  DATA_WIDTH, data_last  out  1  payload stream

## Operation
- States (axi_slave_package enum request_pop_fsm_wr_state): wr_pop_Idle, wr_pop_Hdr, wr_pop_Data.
- wr_pop_Idle: if !aw_fifo_if.FIFO_empty, assert FIFO_rd_en for one cycle, capture head into aw_reg, compute header fields, go wr_pop_Hdr. Else stay.
- wr_pop_Hdr: hdr_valid=1 with registered fields. On hdr_ready: rec_wr_en=1 same cycle, beat_cnt<=0, go wr_pop_Data.
- wr_pop_Data: data_valid = !w_fifo_if.FIFO_empty; data = w head; data_last = (beat_cnt == AWLEN). On data_valid && data_ready: w FIFO_rd_en=1, beat_cnt++; if data_last go wr_pop_Idle.
- Length: bytes = (AWLEN+1) << AWSIZE (17-bit); hdr_len_dw = bytes[11:2] (bytes=4096 → 0). AWSIZE<2 is not generated upstream; treated as AWSIZE=2.
- BE: first_be=4'hF; last_be = (bytes==4) ? 4'h0 : 4'hF.
- generate_tag: id in low $clog2(AWFIFO_DEPTH) bits, upper bits = id ^ 8'hAA pattern (shared with push FSM).
- W FIFO empty in wr_pop_Data: data_valid=0, hold state and beat_cnt.

## Timing
- Reset: state wr_pop_Idle; aw_reg, beat_cnt = 0; all outputs 0 (hdr_valid, data_valid, data_last, rec_wr_en, both FIFO_rd_en low).
- AW non-empty → hdr_valid: 1 cycle. hdr handshake → first data_valid: 1 cycle (if W non-empty).
- Header fields stable while hdr_valid && !hdr_ready; data stable while data_valid && !data_ready.
- One beat per cycle at full throughput; last beat → next FIFO pop in wr_pop_Idle next cycle (1 idle cycle between requests).
- rec_wr_en is a single-cycle pulse coincident with hdr handshake.
- Reset mid-request: abandons request, no partial FIFO pops completed afterwards.

## Structure
- axi_slave_package: request_pop_fsm_wr_state enum, AWFIFO_WIDTH, TAG_WIDTH, generate_tag function (moved there so push and pop share one definition).
- Sub-module axi_wr_len_calc: combinational AWLEN/AWSIZE → hdr_len_dw, first/last BE.

## Test plan
- AWLEN=0, AWSIZE=5, AWID=3, addr 0x1000 → hdr_len_dw=8, first_be=F, last_be=F, tag={0,generate_tag(3)}, one beat with data_last=1, rec_wr_data={3,1}.
- AWLEN=3, AWSIZE=5, data_ready toggling 1/0 → 4 beats in order, data held during stalls, data_last only on 4th; hdr_len_dw=32.
- AWLEN=0, AWSIZE=2 → hdr_len_dw=1, last_be=0.
- AWLEN=127, AWSIZE=5 → bytes 4096, hdr_len_dw=0, 128 beats.
- hdr_ready held low 5 cycles → hdr fields constant, no rec_wr_en, no W pops until accept.
- Two back-to-back AW entries; ARESTn low during 2nd request's beat 1 → all outputs 0 next edge, state wr_pop_Idle.

Source files
------------

// File: rtl/axi_pop_fsm_wr_pkg.sv
// Shared AXI slave request-path definitions: write-pop FSM states, AW FIFO
// layout constants and the tag generator used by both push and pop FSMs.
`default_nettype none

package axi_slave_package;

    localparam int AWFIFO_DEPTH  = 16;
    localparam int TAG_IDX_BITS  = $clog2(AWFIFO_DEPTH);
    localparam int TAG_WIDTH     = 8;
    localparam int AWSIZE_WIDTH  = 3;
    localparam int AWBURST_WIDTH = 2;
    localparam int LEN_DW_WIDTH  = 10;
    localparam int MIN_AWSIZE    = 2;
    // {AWID(4), AWADDR(64), AWLEN(8), AWSIZE(3), AWBURST(2), AWUSER(3), WSTRB(32)}
    localparam int AWFIFO_WIDTH  = 4 + 64 + 8 + AWSIZE_WIDTH + AWBURST_WIDTH + 3 + 32;

    typedef enum logic [1:0] {
        wr_pop_Idle = 2'd0,
        wr_pop_Hdr  = 2'd1,
        wr_pop_Data = 2'd2
    } request_pop_fsm_wr_state;

    // Low bits carry the ID so outstanding tags stay unique per FIFO slot;
    // upper bits are scrambled with a fixed pattern.
    function automatic logic [TAG_WIDTH-2:0] generate_tag(input logic [7:0] id);
        logic [7:0] mix;
        mix = id ^ 8'hAA;
        generate_tag = {mix[TAG_WIDTH-2:TAG_IDX_BITS], id[TAG_IDX_BITS-1:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_if.sv
// Read/write view of a first-word-fall-through synchronous FIFO.
`default_nettype none

interface Sync_FIFO_Interface #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] FIFO_rd_data;
    logic             FIFO_empty;
    logic             FIFO_rd_en;

    modport SINK_FIFO   (input FIFO_rd_data, input FIFO_empty, output FIFO_rd_en);
    modport SOURCE_FIFO (output FIFO_rd_data, output FIFO_empty, input FIFO_rd_en);
endinterface

`default_nettype wire

// File: rtl/axi_wr_len_calc.sv
// Combinational AWLEN/AWSIZE to PCIe payload length (DW) and byte enables.
`default_nettype none

module axi_wr_len_calc
    import axi_slave_package::*;
#(
    parameter int LEN_WIDTH = 8
) (
    input  logic [LEN_WIDTH-1:0]    awlen_i,
    input  logic [AWSIZE_WIDTH-1:0] awsize_i,
    output logic [LEN_DW_WIDTH-1:0] len_dw_o,
    output logic [3:0]              first_be_o,
    output logic [3:0]              last_be_o
);

    logic [AWSIZE_WIDTH-1:0] size_eff;
    logic [16:0]             bytes;
    logic                    unused_bytes;

    always_comb begin
        // Sub-DW beat sizes never come from upstream; clamp to one DW.
        size_eff = (awsize_i < AWSIZE_WIDTH'(MIN_AWSIZE)) ? AWSIZE_WIDTH'(MIN_AWSIZE) : awsize_i;
        bytes    = (17'(awlen_i) + 17'd1) << size_eff;
    end

    assign len_dw_o     = bytes[11:2];
    assign first_be_o   = 4'hF;
    assign last_be_o    = (bytes == 17'd4) ? 4'h0 : 4'hF;
    assign unused_bytes = ^{bytes[16:12], bytes[1:0]};

endmodule

`default_nettype wire

// File: rtl/axi_pop_fsm_wr.sv
// Write-request pop stage: drains one AW entry plus its W beats and presents
// them to the TLP generator as a memory-write header and payload stream.
`default_nettype none

module axi_pop_fsm_wr #(
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 64,
    parameter int LEN_WIDTH    = 8,
    parameter int DATA_WIDTH   = 256,
    parameter int AWUSER_WIDTH = 3,
    parameter int TAG_WIDTH    = 8
) (
    input  logic                    axi_clk,
    input  logic                    ARESTn,
    Sync_FIFO_Interface.SINK_FIFO   aw_fifo_if,
    Sync_FIFO_Interface.SINK_FIFO   w_fifo_if,
    output logic                    rec_wr_en,
    output logic [TAG_WIDTH-1:0]    rec_wr_addr,
    output logic [ID_WIDTH:0]       rec_wr_data,
    output logic                    hdr_valid,
    input  logic                    hdr_ready,
    output logic [TAG_WIDTH-1:0]    hdr_tag,
    output logic [ADDR_WIDTH-1:0]   hdr_addr,
    output logic [9:0]              hdr_len_dw,
    output logic [3:0]              hdr_first_be,
    output logic [3:0]              hdr_last_be,
    output logic [AWUSER_WIDTH-1:0] hdr_type,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    data_last
);

    import axi_slave_package::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int USER_LSB   = STRB_WIDTH;
    localparam int BURST_LSB  = USER_LSB + AWUSER_WIDTH;
    localparam int SIZE_LSB   = BURST_LSB + AWBURST_WIDTH;
    localparam int LEN_LSB    = SIZE_LSB + AWSIZE_WIDTH;
    localparam int ADDR_LSB   = LEN_LSB + LEN_WIDTH;
    localparam int ID_LSB     = ADDR_LSB + ADDR_WIDTH;

    request_pop_fsm_wr_state state_q, state_d;
    logic [LEN_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic                    run_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [AWUSER_WIDTH-1:0] user_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [9:0]              len_dw_q;
    logic [3:0]              first_be_q, last_be_q;

    logic [ID_WIDTH-1:0]     head_id;
    logic [LEN_WIDTH-1:0]    head_len;
    logic [AWSIZE_WIDTH-1:0] head_size;
    logic [9:0]              calc_len_dw;
    logic [3:0]              calc_first_be, calc_last_be;
    logic                    aw_pop, w_pop;
    logic                    unused_fields;

    assign head_id       = aw_fifo_if.FIFO_rd_data[ID_LSB +: ID_WIDTH];
    assign head_len      = aw_fifo_if.FIFO_rd_data[LEN_LSB +: LEN_WIDTH];
    assign head_size     = aw_fifo_if.FIFO_rd_data[SIZE_LSB +: AWSIZE_WIDTH];
    assign unused_fields = ^{aw_fifo_if.FIFO_rd_data[BURST_LSB +: AWBURST_WIDTH],
                             aw_fifo_if.FIFO_rd_data[STRB_WIDTH-1:0]};

    axi_wr_len_calc #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_len_calc (
        .awlen_i    (head_len),
        .awsize_i   (head_size),
        .len_dw_o   (calc_len_dw),
        .first_be_o (calc_first_be),
        .last_be_o  (calc_last_be)
    );

    // run_q keeps FIFO pops off while reset is asserted and on the release edge.
    always_ff @(posedge axi_clk or negedge ARESTn) begin
        if (!ARESTn) begin
            state_q    <= wr_pop_Idle;
            beat_cnt_q <= '0;
            run_q      <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            user_q     <= '0;
            tag_q      <= '0;
            len_dw_q   <= '0;
            first_be_q <= '0;
            last_be_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            run_q      <= 1'b1;
            if (aw_pop) begin
                id_q       <= head_id;
                addr_q     <= aw_fifo_if.FIFO_rd_data[ADDR_LSB +: ADDR_WIDTH];
                len_q      <= head_len;
                user_q     <= aw_fifo_if.FIFO_rd_data[USER_LSB +: AWUSER_WIDTH];
                tag_q      <= TAG_WIDTH'({1'b0, generate_tag(8'(head_id))});
                len_dw_q   <= calc_len_dw;
                first_be_q <= calc_first_be;
                last_be_q  <= calc_last_be;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        aw_pop     = 1'b0;
        w_pop      = 1'b0;
        hdr_valid  = 1'b0;
        rec_wr_en  = 1'b0;
        data_valid = 1'b0;
        data_last  = 1'b0;
        case (state_q)
            wr_pop_Idle: begin
                if (run_q && !aw_fifo_if.FIFO_empty) begin
                    aw_pop  = 1'b1;
                    state_d = wr_pop_Hdr;
                end
            end
            wr_pop_Hdr: begin
                hdr_valid = 1'b1;
                if (hdr_ready) begin
                    rec_wr_en  = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = wr_pop_Data;
                end
            end
            wr_pop_Data: begin
                data_valid = !w_fifo_if.FIFO_empty;
                data_last  = (beat_cnt_q == len_q);
                if (data_valid && data_ready) begin
                    w_pop      = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (data_last) begin
                        state_d = wr_pop_Idle;
                    end
                end
            end
            default: state_d = wr_pop_Idle;
        endcase
    end

    assign aw_fifo_if.FIFO_rd_en = aw_pop;
    assign w_fifo_if.FIFO_rd_en  = w_pop;

    assign hdr_tag      = tag_q;
    assign hdr_addr     = addr_q;
    assign hdr_len_dw   = len_dw_q;
    assign hdr_first_be = first_be_q;
    assign hdr_last_be  = last_be_q;
    assign hdr_type     = user_q;
    assign rec_wr_addr  = tag_q;
    assign rec_wr_data  = {id_q, 1'b1};
    assign data         = w_fifo_if.FIFO_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_axi_pop_fsm_wr.sv
// Scoreboard bench for axi_pop_fsm_wr with queue-modelled AW/W FIFOs.
`default_nettype none

module tb_axi_pop_fsm_wr;

    localparam int AW_W = 116;
    localparam int DW   = 256;

    typedef struct {
        logic [7:0]  tag;
        logic [63:0] addr;
        logic [9:0]  len_dw;
        logic [3:0]  lbe;
        logic [2:0]  user;
        logic [3:0]  id;
    } hdr_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic ARESTn;
    always #5 clk = ~clk;

    Sync_FIFO_Interface #(.WIDTH(AW_W)) aw_if();
    Sync_FIFO_Interface #(.WIDTH(DW))   w_if();

    logic          rec_wr_en;
    logic [7:0]    rec_wr_addr;
    logic [4:0]    rec_wr_data;
    logic          hdr_valid, hdr_ready;
    logic [7:0]    hdr_tag;
    logic [63:0]   hdr_addr;
    logic [9:0]    hdr_len_dw;
    logic [3:0]    hdr_first_be, hdr_last_be;
    logic [2:0]    hdr_type;
    logic          data_valid, data_ready, data_last;
    logic [DW-1:0] data;

    axi_pop_fsm_wr dut (
        .axi_clk      (clk),
        .ARESTn       (ARESTn),
        .aw_fifo_if   (aw_if),
        .w_fifo_if    (w_if),
        .rec_wr_en    (rec_wr_en),
        .rec_wr_addr  (rec_wr_addr),
        .rec_wr_data  (rec_wr_data),
        .hdr_valid    (hdr_valid),
        .hdr_ready    (hdr_ready),
        .hdr_tag      (hdr_tag),
        .hdr_addr     (hdr_addr),
        .hdr_len_dw   (hdr_len_dw),
        .hdr_first_be (hdr_first_be),
        .hdr_last_be  (hdr_last_be),
        .hdr_type     (hdr_type),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data         (data),
        .data_last    (data_last)
    );

    logic [AW_W-1:0] aw_q[$];
    logic [DW-1:0]   w_q[$];
    hdr_t            exp_h[$];
    beat_t           exp_b[$];

    int n_cmp = 0;
    int n_bad = 0;
    int beats_seen = 0;
    int hdr_mode = 1;   // 0 random, 1 high, 2 low
    int data_mode = 1;  // 0 random, 1 high, 2 toggle

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void refresh();
        aw_if.FIFO_empty   = (aw_q.size() == 0);
        aw_if.FIFO_rd_data = (aw_q.size() == 0) ? '0 : aw_q[0];
        w_if.FIFO_empty    = (w_q.size() == 0);
        w_if.FIFO_rd_data  = (w_q.size() == 0) ? '0 : w_q[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO source model and ready generators; all updates land at posedge+1.
    always begin
        logic pa, pw;
        @(posedge clk);
        pa = aw_if.FIFO_rd_en;
        pw = w_if.FIFO_rd_en;
        #1;
        if (pa) begin
            chk("aw_pop_nonempty", DW'(aw_q.size() != 0), DW'(1));
            if (aw_q.size() != 0) void'(aw_q.pop_front());
        end
        if (pw) begin
            chk("w_pop_nonempty", DW'(w_q.size() != 0), DW'(1));
            if (w_q.size() != 0) void'(w_q.pop_front());
        end
        case (hdr_mode)
            0:       hdr_ready = 1'($urandom_range(0, 1));
            2:       hdr_ready = 1'b0;
            default: hdr_ready = 1'b1;
        endcase
        case (data_mode)
            0:       data_ready = ($urandom_range(0, 3) != 0);
            2:       data_ready = ~data_ready;
            default: data_ready = 1'b1;
        endcase
        refresh();
    end

    // Monitor: compares every header/beat handshake against the scoreboard.
    logic [92:0]   cur_h, hsaved;
    logic [DW-1:0] dsaved;
    logic          dsaved_last;
    bit            hstall = 0, dstall = 0;
    hdr_t          eh;
    beat_t         eb;

    always @(negedge clk) begin
        if (!ARESTn) begin
            hstall = 0;
            dstall = 0;
        end else begin
            cur_h = {hdr_tag, hdr_addr, hdr_len_dw, hdr_first_be, hdr_last_be, hdr_type};
            if (hstall) chk("hdr_hold", DW'({hdr_valid, cur_h}), DW'({1'b1, hsaved}));
            if (hdr_valid) begin
                if (hdr_ready) begin
                    if (exp_h.size() == 0) begin
                        chk("hdr_unexpected", DW'(1), DW'(0));
                    end else begin
                        eh = exp_h.pop_front();
                        chk("hdr_tag", DW'(hdr_tag), DW'(eh.tag));
                        chk("hdr_addr", DW'(hdr_addr), DW'(eh.addr));
                        chk("hdr_len_dw", DW'(hdr_len_dw), DW'(eh.len_dw));
                        chk("hdr_first_be", DW'(hdr_first_be), DW'(4'hF));
                        chk("hdr_last_be", DW'(hdr_last_be), DW'(eh.lbe));
                        chk("hdr_type", DW'(hdr_type), DW'(eh.user));
                        chk("rec_wr_en", DW'(rec_wr_en), DW'(1));
                        chk("rec_wr_addr", DW'(rec_wr_addr), DW'(eh.tag));
                        chk("rec_wr_data", DW'(rec_wr_data), DW'({eh.id, 1'b1}));
                    end
                end else begin
                    chk("rec_wr_en_stall", DW'(rec_wr_en), DW'(0));
                end
            end else begin
                chk("rec_wr_en_idle", DW'(rec_wr_en), DW'(0));
            end
            hstall = hdr_valid && !hdr_ready;
            hsaved = cur_h;

            if (dstall) begin
                chk("data_hold", data, dsaved);
                chk("data_hold_ctl", DW'({data_valid, data_last}), DW'({1'b1, dsaved_last}));
            end
            if (data_valid) begin
                chk("w_rd_en", DW'(w_if.FIFO_rd_en), DW'(data_ready));
                if (data_ready) begin
                    if (exp_b.size() == 0) begin
                        chk("beat_unexpected", DW'(1), DW'(0));
                    end else begin
                        eb = exp_b.pop_front();
                        chk("beat_data", data, eb.d);
                        chk("beat_last", DW'(data_last), DW'(eb.last));
                    end
                    beats_seen++;
                end
            end else begin
                chk("w_rd_en_idle", DW'(w_if.FIFO_rd_en), DW'(0));
            end
            dstall      = data_valid && !data_ready;
            dsaved      = data;
            dsaved_last = data_last;
        end
    end

    // Reference model: request rules expressed as plain arithmetic.
    task automatic send_req(input logic [3:0] id, input logic [63:0] addr, input int len,
                            input int size, input logic [2:0] user, input int gap_max);
        hdr_t          h;
        beat_t         b;
        logic [DW-1:0] d;
        int            bytes;
        bytes    = (len + 1) * (1 << ((size < 2) ? 2 : size));
        h.tag    = 8'(((id ^ 8'hAA) & 8'h70) | (id & 8'h0F));
        h.addr   = addr;
        h.len_dw = 10'((bytes / 4) % 1024);
        h.lbe    = (bytes == 4) ? 4'h0 : 4'hF;
        h.user   = user;
        h.id     = id;
        exp_h.push_back(h);
        aw_q.push_back({id, addr, 8'(len), 3'(size), 2'b01, user, 32'hFFFF_FFFF});
        refresh();
        for (int i = 0; i <= len; i++) begin
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
            b.d    = d;
            b.last = (i == len);
            exp_b.push_back(b);
            w_q.push_back(d);
            refresh();
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic wait_drain(input string nm, input int maxc);
        bit done;
        done = 0;
        for (int i = 0; i < maxc; i++) begin
            if (exp_h.size() == 0 && exp_b.size() == 0) begin
                done = 1;
                break;
            end
            tick();
        end
        chk(nm, DW'(done), DW'(1));
        repeat (3) tick();
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk(nm, DW'({hdr_valid, data_valid, data_last, rec_wr_en,
                     aw_if.FIFO_rd_en, w_if.FIFO_rd_en}), DW'(0));
        chk({nm, "_regs"}, DW'({hdr_addr, hdr_len_dw}), DW'(0));
    endtask

    initial begin
        int base;
        bit reached;
        ARESTn     = 1'b0;
        hdr_ready  = 1'b1;
        data_ready = 1'b1;
        refresh();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset_state");
        tick();
        #1 ARESTn = 1'b1;
        repeat (3) tick();

        // Single beat, 32 bytes: concrete values and latencies.
        send_req(4'd3, 64'h1000, 0, 5, 3'd0, 0);
        @(negedge clk);
        chk("aw_pop_latency", DW'({aw_if.FIFO_rd_en, hdr_valid}), DW'(2'b10));
        @(negedge clk);
        chk("hdr_valid_latency", DW'(hdr_valid), DW'(1));
        chk("hdr_tag_id3", DW'(hdr_tag), DW'(8'h23));
        chk("hdr_len_dw_32B", DW'(hdr_len_dw), DW'(8));
        chk("rec_data_id3", DW'(rec_wr_data), DW'(5'b00111));
        @(negedge clk);
        chk("first_beat_latency", DW'({data_valid, data_last}), DW'(2'b11));
        wait_drain("drain_single", 100);

        data_mode = 2;
        send_req(4'($urandom()), {$urandom(), $urandom()}, 3, 5, 3'd1, 0);
        wait_drain("drain_toggle", 200);
        data_mode = 1;

        send_req(4'd9, 64'h2000, 0, 2, 3'd2, 0);
        wait_drain("drain_one_dw", 100);

        send_req(4'd5, 64'h3000, 127, 5, 3'd4, 0);
        wait_drain("drain_4k", 2000);

        hdr_mode = 2;
        send_req(4'd12, 64'h4000, 2, 4, 3'd3, 0);
        repeat (6) tick();
        chk("hdr_stall_no_w_pop", DW'(w_q.size()), DW'(3));
        chk("hdr_stall_aw_popped", DW'(aw_q.size()), DW'(0));
        hdr_mode = 1;
        wait_drain("drain_hdr_stall", 200);

        hdr_mode  = 0;
        data_mode = 0;
        for (int r = 0; r < 25; r++) begin
            send_req(4'($urandom()), {$urandom(), $urandom()},
                     ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 7),
                     $urandom_range(0, 5), 3'($urandom()), 2);
        end
        wait_drain("drain_random", 3000);

        // Reset while the second of two back-to-back requests is on beat 1.
        hdr_mode  = 1;
        data_mode = 1;
        base      = beats_seen;
        send_req(4'd1, 64'h5000, 3, 5, 3'd0, 0);
        send_req(4'd2, 64'h6000, 3, 5, 3'd0, 0);
        reached = 0;
        for (int i = 0; i < 200; i++) begin
            if (beats_seen >= base + 5) begin
                reached = 1;
                break;
            end
            tick();
        end
        chk("reset_point_reached", DW'(reached), DW'(1));
        #1 ARESTn = 1'b0;
        aw_q.delete();
        w_q.delete();
        exp_h.delete();
        exp_b.delete();
        refresh();
        send_req(4'd7, 64'h7000, 1, 3, 3'd5, 0);
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        tick();
        #1 ARESTn = 1'b1;
        wait_drain("drain_after_reset", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
